rv_lsu: RTL and testbench

Load/store unit between the execute stage of `RV_top` and its data-memory port (`DMem*`). It accepts one load or store per transaction from execute and runs the address/data handshake toward the data memory. Loaded bytes and halfwords are sign- or zero-extended before writeback. Misaligned and out-of-range accesses are trapped before any bus activity.

---
 rtl/rv_lsu.sv | 175 +++++++++++++++++
 tb/tb_rv_lsu.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit between execute and the data-memory port.
// Illegal accesses trap up front; legal ones run the DMem address/data handshake.
module rv_lsu #(
  parameter logic [31:0] DMEM_BASE = 32'h0000_1000,
  parameter logic [31:0] DMEM_SIZE = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_op,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        DMemAddress_vld,
  output logic [31:0] DMemAddress,
  output logic        DMemOp,
  output logic [1:0]  DMemOpSize,
  input  logic        DMemAddress_rsp,
  output logic        DMemWData_vld,
  output logic [31:0] DMemWriteData,
  input  logic [31:0] DMemReadData,
  input  logic        DMemData_rsp,
  output logic        wb_vld,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        exc_vld,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} lsuState_t;

  // 33-bit window bounds so BASE+SIZE and addr+bytes never wrap.
  localparam logic [32:0] WinLo = {1'b0, DMEM_BASE};
  localparam logic [32:0] WinHi = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};

  lsuState_t   state;
  logic        opReg;
  logic [2:0]  funct3Reg;
  logic [4:0]  rdReg;

  logic        funct3Ok;
  logic        misaligned;
  logic        outOfRange;
  logic        dataDone;
  logic [1:0]  reqSize;
  logic [32:0] accessBytes;
  logic [32:0] accessEnd;
  logic [31:0] storeData;
  logic [31:0] loadExt;

  always_comb begin
    reqSize     = 2'b11;
    accessBytes = 33'd4;
    storeData   = req_wdata;
    funct3Ok    = 1'b1;
    case (req_funct3)
      3'b000, 3'b100: begin
        reqSize     = 2'b00;
        accessBytes = 33'd1;
        storeData   = {24'd0, req_wdata[7:0]};
      end
      3'b001, 3'b101: begin
        reqSize     = 2'b01;
        accessBytes = 33'd2;
        storeData   = {16'd0, req_wdata[15:0]};
      end
      3'b010:  funct3Ok = 1'b1;
      default: funct3Ok = 1'b0;
    endcase
    // Unsigned variants only exist for loads.
    if (req_op && req_funct3[2]) begin
      funct3Ok = 1'b0;
    end
    misaligned = !funct3Ok || (reqSize[0] && req_addr[0]) || (reqSize[1] && req_addr[1]);
    accessEnd  = {1'b0, req_addr} + accessBytes;
    outOfRange = ({1'b0, req_addr} < WinLo) || (accessEnd > WinHi);
  end

  always_comb begin
    case (funct3Reg)
      3'b000:  loadExt = {{24{DMemReadData[7]}}, DMemReadData[7:0]};
      3'b100:  loadExt = {24'd0, DMemReadData[7:0]};
      3'b001:  loadExt = {{16{DMemReadData[15]}}, DMemReadData[15:0]};
      3'b101:  loadExt = {16'd0, DMemReadData[15:0]};
      default: loadExt = DMemReadData;
    endcase
  end

  // DMemData_rsp only counts in ADDR when the address phase completes in the same cycle.
  assign dataDone = ((state == ADDR) && DMemAddress_rsp && DMemData_rsp)
                 || ((state == DATA) && DMemData_rsp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_rdy         <= 1'b1;
      opReg           <= 1'b0;
      funct3Reg       <= 3'd0;
      rdReg           <= 5'd0;
      DMemAddress_vld <= 1'b0;
      DMemAddress     <= 32'd0;
      DMemOp          <= 1'b0;
      DMemOpSize      <= 2'b00;
      DMemWData_vld   <= 1'b0;
      DMemWriteData   <= 32'd0;
      wb_vld          <= 1'b0;
      wb_rd           <= 5'd0;
      wb_data         <= 32'd0;
      done            <= 1'b0;
      exc_vld         <= 1'b0;
      exc_cause       <= 2'b00;
      exc_addr        <= 32'd0;
    end else begin
      done    <= 1'b0;
      exc_vld <= 1'b0;
      wb_vld  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_vld) begin
            opReg     <= req_op;
            funct3Reg <= req_funct3;
            rdReg     <= req_rd;
            req_rdy   <= 1'b0;
            if (misaligned || outOfRange) begin
              state     <= RESP;
              done      <= 1'b1;
              exc_vld   <= 1'b1;
              exc_cause <= misaligned ? 2'b01 : 2'b10;
              exc_addr  <= req_addr;
            end else begin
              state           <= ADDR;
              DMemAddress_vld <= 1'b1;
              DMemAddress     <= req_addr;
              DMemOp          <= req_op;
              DMemOpSize      <= reqSize;
              DMemWData_vld   <= req_op;
              DMemWriteData   <= req_op ? storeData : 32'd0;
            end
          end
        end
        ADDR: begin
          if (DMemAddress_rsp) begin
            state           <= DATA;
            DMemAddress_vld <= 1'b0;
          end
        end
        RESP: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
        end
        default: ;
      endcase
      // Completion overrides the ADDR->DATA move when both phases finish together.
      if (dataDone) begin
        state           <= RESP;
        done            <= 1'b1;
        DMemAddress_vld <= 1'b0;
        DMemAddress     <= 32'd0;
        DMemOp          <= 1'b0;
        DMemOpSize      <= 2'b00;
        DMemWData_vld   <= 1'b0;
        DMemWriteData   <= 32'd0;
        if (!opReg) begin
          wb_data <= loadExt;
          wb_rd   <= rdReg;
          wb_vld  <= (rdReg != 5'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Self-checking bench for rv_lsu: directed scenarios then randomized ops
// against an arithmetic reference model of the access rules.
module tb_rv_lsu;
  localparam longint Base = 64'h1000;
  localparam longint Size = 64'h1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic        req_op;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        DMemAddress_vld;
  logic [31:0] DMemAddress;
  logic        DMemOp;
  logic [1:0]  DMemOpSize;
  logic        DMemAddress_rsp;
  logic        DMemWData_vld;
  logic [31:0] DMemWriteData;
  logic [31:0] DMemReadData;
  logic        DMemData_rsp;
  logic        wb_vld;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        exc_vld;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  int testCount = 0;
  int failCount = 0;

  rv_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .DMemAddress_vld(DMemAddress_vld), .DMemAddress(DMemAddress), .DMemOp(DMemOp),
    .DMemOpSize(DMemOpSize), .DMemAddress_rsp(DMemAddress_rsp),
    .DMemWData_vld(DMemWData_vld), .DMemWriteData(DMemWriteData),
    .DMemReadData(DMemReadData), .DMemData_rsp(DMemData_rsp),
    .wb_vld(wb_vld), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
    .exc_vld(exc_vld), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte count, trap cause, bus size code, masked store data, extended load data.
  function automatic void model(input bit op, input bit [2:0] f3, input bit [31:0] addr,
                                input bit [31:0] wd, input bit [31:0] rdat,
                                output int cause, output bit [1:0] sz,
                                output bit [31:0] wexp, output bit [31:0] lexp);
    int     nbytes;
    bit     legal;
    longint a;
    longint m;
    longint v;
    legal  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!op && (f3 == 3'd4 || f3 == 3'd5));
    nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    a      = {32'd0, addr};
    cause  = 0;
    if (!legal || (a % nbytes) != 0) cause = 1;
    else if (a < Base || a + nbytes > Base + Size) cause = 2;
    sz   = 2'(nbytes - 1);
    m    = longint'(1) << (8 * nbytes);
    wexp = 32'({32'd0, wd} % m);
    v    = {32'd0, rdat} % m;
    if (f3 < 3'd2 && v >= m / 2) v = v - m;
    lexp = 32'(v);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rdy"}, 32'(req_rdy), 32'd1);
    chk({tag, " flags"}, 32'({DMemAddress_vld, DMemWData_vld, wb_vld, done, exc_vld}), 32'd0);
    chk({tag, " fields"}, 32'({DMemOp, DMemOpSize, wb_rd, exc_cause}), 32'd0);
    chk({tag, " addr"}, DMemAddress | DMemWriteData, 32'd0);
    chk({tag, " data"}, wb_data | exc_addr, 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns one negedge after RESP.
  task automatic run_op(input string name, input bit op, input bit [2:0] f3,
                        input bit [31:0] addr, input bit [31:0] wd, input bit [4:0] rd,
                        input bit [31:0] rdat, input int aStall, input int dStall,
                        input bit together);
    int cause;
    bit [1:0] sz;
    bit [31:0] wexp;
    bit [31:0] lexp;
    bit expWb;
    model(op, f3, addr, wd, rdat, cause, sz, wexp, lexp);
    expWb = !op && (rd != 5'd0);
    $display("[TB] %s op=%0d f3=%0d addr=%h wd=%h rd=%0d rdat=%h stall=%0d/%0d tog=%0d cause=%0d",
             name, op, f3, addr, wd, rd, rdat, aStall, dStall, together, cause);
    chk({name, " req_rdy"}, 32'(req_rdy), 32'd1);
    req_vld = 1'b1; req_op = op; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_vld = 1'b0; req_addr = $urandom(); req_wdata = $urandom(); req_rd = 5'($urandom());
    if (cause != 0) begin
      chk({name, " trap flags"}, 32'({exc_vld, done, wb_vld}), 32'b110);
      chk({name, " exc_cause"}, 32'(exc_cause), 32'(cause));
      chk({name, " exc_addr"}, exc_addr, addr);
      chk({name, " no bus"}, 32'({DMemAddress_vld, DMemWData_vld}), 32'd0);
    end else begin
      for (int i = 0; i <= aStall; i++) begin
        chk({name, " addr phase"}, 32'({DMemAddress_vld, DMemOp, DMemOpSize, DMemWData_vld, done}),
            32'({1'b1, op, sz, op, 1'b0}));
        chk({name, " DMemAddress"}, DMemAddress, addr);
        chk({name, " wdata"}, DMemWriteData, op ? wexp : 32'd0);
        if (i == aStall) begin
          DMemAddress_rsp = 1'b1; DMemData_rsp = together;
          DMemReadData = together ? rdat : $urandom();
        end else begin
          DMemAddress_rsp = 1'b0; DMemData_rsp = 1'($urandom_range(0, 1));
          DMemReadData = $urandom();
        end
        @(negedge clk);
      end
      DMemAddress_rsp = 1'b0; DMemData_rsp = 1'b0;
      if (!together) begin
        for (int i = 0; i <= dStall; i++) begin
          chk({name, " data phase"}, 32'({DMemAddress_vld, DMemWData_vld, done}), 32'({1'b0, op, 1'b0}));
          if (op) chk({name, " held wdata"}, DMemWriteData, wexp);
          DMemData_rsp = (i == dStall);
          DMemReadData = (i == dStall) ? rdat : $urandom();
          @(negedge clk);
        end
        DMemData_rsp = 1'b0;
      end
      chk({name, " resp flags"}, 32'({done, exc_vld, wb_vld, DMemAddress_vld, DMemWData_vld}),
          32'({1'b1, 1'b0, expWb, 1'b0, 1'b0}));
      if (expWb) begin
        chk({name, " wb_data"}, wb_data, lexp);
        chk({name, " wb_rd"}, 32'(wb_rd), 32'(rd));
      end
    end
    @(negedge clk);
    chk({name, " after"}, 32'({req_rdy, done, exc_vld, wb_vld}), 32'b1000);
  endtask

  initial begin
    rst_n = 1'b0; req_vld = 1'b0; req_op = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; req_rd = 5'd0; DMemAddress_rsp = 1'b0; DMemData_rsp = 1'b0;
    DMemReadData = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op("lw_zero_wait", 1'b0, 3'b010, 32'h1010, 32'd0, 5'd5, 32'hDEADBEEF, 0, 0, 1'b1);
    run_op("lb", 1'b0, 3'b000, 32'h1003, 32'd0, 5'd6, 32'h0000_0080, 0, 0, 1'b1);
    run_op("lbu", 1'b0, 3'b100, 32'h1003, 32'd0, 5'd7, 32'h0000_0080, 1, 0, 1'b0);
    run_op("sh_stall", 1'b1, 3'b001, 32'h1022, 32'h1234ABCD, 5'd0, 32'd0, 2, 2, 1'b0);
    run_op("lw_misaligned", 1'b0, 3'b010, 32'h1002, 32'd0, 5'd3, 32'd0, 0, 0, 1'b0);
    run_op("sw_1ffe", 1'b1, 3'b010, 32'h1FFE, 32'h55AA55AA, 5'd0, 32'd0, 0, 0, 1'b0);
    run_op("sw_1ffc", 1'b1, 3'b010, 32'h1FFC, 32'h55AA55AA, 5'd0, 32'd0, 0, 1, 1'b0);
    run_op("lw_0ffc", 1'b0, 3'b010, 32'h0FFC, 32'd0, 5'd4, 32'd0, 0, 0, 1'b0);
    run_op("sb_bu_illegal", 1'b1, 3'b100, 32'h1100, 32'h12, 5'd0, 32'd0, 0, 0, 1'b0);
    run_op("lh_top", 1'b0, 3'b001, 32'h1FFE, 32'd0, 5'd9, 32'h1234_8001, 0, 0, 1'b1);

    // Abort a load while it sits in the data phase.
    req_vld = 1'b1; req_op = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1100; req_rd = 5'd7;
    @(negedge clk);
    req_vld = 1'b0; DMemAddress_rsp = 1'b1;
    @(negedge clk);
    DMemAddress_rsp = 1'b0;
    chk("rstmid in_data", 32'({req_rdy, DMemAddress_vld, done}), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rstmid");
    $display("[TB] reset asserted mid-transaction");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid no_done", 32'(done), 32'd0);
    run_op("lw_after_rst", 1'b0, 3'b010, 32'h1200, 32'd0, 5'd11, 32'hCAFEF00D, 0, 0, 1'b1);
    run_op("lw_rd0", 1'b0, 3'b010, 32'h1204, 32'd0, 5'd0, 32'h11112222, 0, 0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      bit [31:0] base;
      case ($urandom_range(0, 4))
        0: base = 32'h1000;
        1: base = 32'h1FFC;
        2: base = 32'h0FFC;
        3: base = 32'h1000 + ($urandom_range(0, 32'hFFF) & 32'hFFC);
        default: base = $urandom();
      endcase
      run_op("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             base + $urandom_range(0, 3), $urandom(), 5'($urandom()), $urandom(),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
